// File: rtl/power_rail_sequencer_if.sv
// Power-rail sequencer bus: HPS/board side drives requests and raw sense lines,
// the sequencer drives rail enables and status back.
interface power_rail_sequencer_if;
  logic       enable_request;
  logic       fault_clear;
  logic [5:0] power_sense;
  logic [1:0] power_control;
  logic [2:0] state;
  logic       fault;
  logic [5:0] fault_code;
  logic       timeout_fault;

  modport master (
    output enable_request,
    output fault_clear,
    output power_sense,
    input  power_control,
    input  state,
    input  fault,
    input  fault_code,
    input  timeout_fault
  );

  modport slave (
    input  enable_request,
    input  fault_clear,
    input  power_sense,
    output power_control,
    output state,
    output fault,
    output fault_code,
    output timeout_fault
  );
endinterface

// File: rtl/power_rail_sequencer.sv
// Two-rail power sequencer with debounced sense inputs, latched faults and ordered shutdown.
// Optional automatic fault retry is enabled by defining POWER_SEQ_AUTO_RETRY_EN.
module power_rail_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES   = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000,
  parameter logic [5:0]  RAIL0_MASK      = 6'b000111,
  parameter logic [5:0]  RAIL1_MASK      = 6'b111000
) (
  input logic                   clock,
  input logic                   reset,
  power_rail_sequencer_if.slave bus
);

  localparam int unsigned DebW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TimerMax = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                      : SETTLE_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [DebW-1:0]   DebLast     = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] SettleLast  = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0] SettleFull  = TimerW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    StOff       = 3'd0,
    StRail0Up   = 3'd1,
    StSettle    = 3'd2,
    StRail1Up   = 3'd3,
    StOn        = 3'd4,
    StRail1Down = 3'd5,
    StFault     = 3'd6
  } state_e;

  logic [5:0]        r_sync1;
  logic [5:0]        r_sync2;
  logic [5:0]        r_deb;
  logic [DebW-1:0]   r_deb_cnt [6];
  state_e            r_state;
  logic [TimerW-1:0] r_timer;
  logic [1:0]        r_ctrl;
  logic              r_fault;
  logic [5:0]        r_fault_code;
  logic              r_timeout_fault;

  state_e            w_state_next;
  logic [TimerW-1:0] w_timer_next;
  logic [1:0]        w_ctrl_next;
  logic              w_good0;
  logic              w_good1;
  logic              w_timeout;
  logic              w_timeout_hit;
  logic              w_fault_enter;
  logic              w_fault_exit;
  logic              w_retry_go;

  // Sense conditioning: 2-flop synchroniser, then a per-bit run-length debouncer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 6; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.power_sense;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 6; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DebLast) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_good0   = &(r_deb | ~RAIL0_MASK);
  assign w_good1   = &(r_deb | ~RAIL1_MASK);
  assign w_timeout = (r_timer == TimeoutLast);

  // Within each state: fault first, then enable_request drop, then forward progress.
  always_comb begin
    w_state_next  = r_state;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      StOff: begin
        if (bus.enable_request && !r_fault) w_state_next = StRail0Up;
      end
      StRail0Up: begin
        if (w_timeout) begin
          w_state_next  = StFault;
          w_timeout_hit = 1'b1;
        end else if (!bus.enable_request) begin
          w_state_next = StOff;
        end else if (w_good0) begin
          w_state_next = StSettle;
        end
      end
      StSettle: begin
        if (!w_good0)                    w_state_next = StFault;
        else if (!bus.enable_request)    w_state_next = StOff;
        else if (r_timer == SettleLast)  w_state_next = StRail1Up;
      end
      StRail1Up: begin
        if (!w_good0) begin
          w_state_next = StFault;
        end else if (w_timeout) begin
          w_state_next  = StFault;
          w_timeout_hit = 1'b1;
        end else if (!bus.enable_request) begin
          w_state_next = StRail1Down;
        end else if (w_good1) begin
          w_state_next = StOn;
        end
      end
      StOn: begin
        if (!w_good0 || !w_good1)     w_state_next = StFault;
        else if (!bus.enable_request) w_state_next = StRail1Down;
      end
      StRail1Down: begin
        if (r_timer == SettleLast) w_state_next = StOff;
      end
      StFault: begin
        if (bus.fault_clear && (r_ctrl == 2'b00) && !bus.enable_request) begin
          w_state_next = StOff;
        end else if (w_retry_go) begin
          w_state_next = StRail0Up;
        end
      end
      default: w_state_next = StOff;
    endcase
  end

  always_comb begin
    w_fault_enter = (w_state_next == StFault) && (r_state != StFault);
    w_fault_exit  = (r_state == StFault) && (w_state_next != StFault);
    if (w_state_next != r_state) w_timer_next = '0;
    else if (&r_timer)           w_timer_next = r_timer;
    else                         w_timer_next = r_timer + 1'b1;
    // Control follows the next state and timer so it is registered alongside them.
    unique case (w_state_next)
      StRail0Up, StSettle, StRail1Down: w_ctrl_next = 2'b01;
      StRail1Up, StOn:                  w_ctrl_next = 2'b11;
      StFault: w_ctrl_next = (w_timer_next >= SettleFull) ? 2'b00 : 2'b01;
      default:                          w_ctrl_next = 2'b00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= StOff;
      r_timer         <= '0;
      r_ctrl          <= 2'b00;
      r_fault         <= 1'b0;
      r_fault_code    <= '0;
      r_timeout_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_ctrl  <= w_ctrl_next;
      if (w_fault_enter) begin
        r_fault         <= 1'b1;
        r_fault_code    <= ~r_deb & (RAIL0_MASK | RAIL1_MASK);
        r_timeout_fault <= w_timeout_hit;
      end else if (w_fault_exit) begin
        r_fault         <= 1'b0;
        r_fault_code    <= '0;
        r_timeout_fault <= 1'b0;
      end
    end
  end

`ifdef POWER_SEQ_AUTO_RETRY_EN
  localparam int unsigned RetryWait = SETTLE_CYCLES * 4;
  localparam int unsigned RetryW    = $clog2(RetryWait + 1);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(RetryWait - 1);

  logic [1:0]        r_retry_cnt;
  logic [RetryW-1:0] r_retry_wait;
  logic              w_retry_armed;

  assign w_retry_armed = (r_state == StFault) && (r_ctrl == 2'b00) && bus.enable_request &&
                         (r_retry_cnt != 2'd3);
  assign w_retry_go    = w_retry_armed && (r_retry_wait == RetryLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retry_cnt  <= '0;
      r_retry_wait <= '0;
    end else begin
      r_retry_wait <= (w_retry_armed && !w_retry_go) ? r_retry_wait + 1'b1 : '0;
      if ((r_state == StOff) || (w_state_next == StOn)) r_retry_cnt <= '0;
      else if (w_retry_go)                              r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end
`else
  assign w_retry_go = 1'b0;
`endif

  assign bus.power_control = r_ctrl;
  assign bus.state         = r_state;
  assign bus.fault         = r_fault;
  assign bus.fault_code    = r_fault_code;
  assign bus.timeout_fault = r_timeout_fault;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Directed-random bench for power_rail_sequencer; expected timing and codes are derived
// arithmetically from the sequencing rules (sense latency, settle and timeout lengths).
module tb_power_rail_sequencer;
  localparam int unsigned Deb      = 4;
  localparam int unsigned Settle   = 20;
  localparam int unsigned Timeout  = 100;
  // Sense change -> debounced (Deb+2) -> FSM reacts one edge later.
  localparam int unsigned SenseLat = Deb + 3;

  localparam logic [2:0] StOff = 3'd0, StRail0Up = 3'd1, StSettle = 3'd2, StRail1Up = 3'd3;
  localparam logic [2:0] StOn = 3'd4, StRail1Down = 3'd5, StFault = 3'd6;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  power_rail_sequencer_if bus ();

  power_rail_sequencer #(
    .DEBOUNCE_CYCLES(Deb),
    .SETTLE_CYCLES  (Settle),
    .TIMEOUT_CYCLES (Timeout),
    .RAIL0_MASK     (6'b000111),
    .RAIL1_MASK     (6'b111000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Reference: lines reported at fault entry are exactly the monitored lines not good.
  function automatic logic [5:0] exp_code(input logic [5:0] settled_sense);
    return ~settled_sense & 6'b111111;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (bus.state !== s && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ctrl(input logic [1:0] c, input int budget, output int n);
    n = 0;
    while (bus.power_control !== c && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic clear_sense();
    bus.power_sense = 6'b000000;
    repeat (SenseLat + 1) step();
  endtask

  task automatic pulse_clear();
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
  endtask

  task automatic power_up();
    int n;
    int d0;
    int d1;
    d0 = $urandom_range(2, 30);
    d1 = $urandom_range(2, 30);
    bus.enable_request = 1'b1;
    wait_state(StRail0Up, 5, n);
    check("rail0_up_latency", n, 1);
    check("rail0_up_ctrl", bus.power_control, 2'b01);
    repeat (d0) step();
    bus.power_sense = 6'b000111;
    wait_state(StSettle, 30, n);
    check("good0_latency", n, SenseLat);
    wait_ctrl(2'b11, 40, n);
    check("settle_length", n, Settle);
    check("rail1_up_state", bus.state, StRail1Up);
    repeat (d1) step();
    bus.power_sense = 6'b111111;
    wait_state(StOn, 30, n);
    check("good1_latency", n, SenseLat);
    check("on_ctrl", bus.power_control, 2'b11);
  endtask

  task automatic glitch(input int b, input int len);
    bus.power_sense = 6'b111111 & ~(6'b1 << b);
    repeat (len) step();
    bus.power_sense = 6'b111111;
    repeat (SenseLat + 3) step();
    check("glitch_state", bus.state, StOn);
    check("glitch_fault", bus.fault, 1'b0);
  endtask

  task automatic brownout_and_clear(input int b);
    int n;
    logic [5:0] s;
    s = 6'b111111 & ~(6'b1 << b);
    bus.power_sense = s;
    wait_state(StFault, 30, n);
    check("brownout_latency", n, SenseLat);
    check("brownout_fault", bus.fault, 1'b1);
    check("brownout_code", bus.fault_code, exp_code(s));
    check("brownout_tfault", bus.timeout_fault, 1'b0);
    check("brownout_ctrl", bus.power_control, 2'b01);
    repeat (3) step();
    bus.power_sense = 6'b111111;
    wait_ctrl(2'b00, 40, n);
    check("fault_shutdown_len", n, Settle - 3);
    pulse_clear();
    check("clear_ignored_en", bus.state, StFault);
    bus.enable_request = 1'b0;
    pulse_clear();
    check("clear_state", bus.state, StOff);
    check("clear_fault", bus.fault, 1'b0);
    check("clear_code", bus.fault_code, 6'b0);
  endtask

  initial begin
    int n;
    reset              = 1'b1;
    bus.enable_request = 1'b0;
    bus.fault_clear    = 1'b0;
    bus.power_sense    = 6'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ctrl", bus.power_control, 2'b00);
    check("rst_state", bus.state, StOff);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_code", bus.fault_code, 6'b0);
    check("rst_tfault", bus.timeout_fault, 1'b0);
    reset = 1'b0;
    step();

    for (int it = 0; it < 3; it++) begin
      clear_sense();
      power_up();
      glitch((it == 0) ? 0 : $urandom_range(0, 5), (it == 0) ? 2 : $urandom_range(1, Deb - 1));
      brownout_and_clear((it == 0) ? 4 : $urandom_range(0, 5));
    end

    // Orderly shutdown from ON.
    clear_sense();
    power_up();
    bus.enable_request = 1'b0;
    wait_state(StRail1Down, 5, n);
    check("down_latency", n, 1);
    check("down_ctrl", bus.power_control, 2'b01);
    wait_ctrl(2'b00, 40, n);
    check("down_length", n, Settle);
    check("down_state", bus.state, StOff);

    // Rail 0 never comes good.
    clear_sense();
    bus.enable_request = 1'b1;
    wait_state(StRail0Up, 5, n);
    wait_state(StFault, Timeout + 20, n);
    check("to0_latency", n, Timeout);
    check("to0_tfault", bus.timeout_fault, 1'b1);
    check("to0_code", bus.fault_code, exp_code(6'b000000));
    check("to0_ctrl", bus.power_control, 2'b01);
    bus.enable_request = 1'b0;
    pulse_clear();
    check("early_clear_ignored", bus.state, StFault);
    wait_ctrl(2'b00, 40, n);
    check("to0_shutdown_len", n, Settle - 1);
    pulse_clear();
    check("to0_exit_state", bus.state, StOff);
    check("to0_exit_tfault", bus.timeout_fault, 1'b0);

    // Rail 1 never comes good.
    bus.enable_request = 1'b1;
    wait_state(StRail0Up, 5, n);
    repeat ($urandom_range(1, 10)) step();
    bus.power_sense = 6'b000111;
    wait_state(StRail1Up, 60, n);
    wait_state(StFault, Timeout + 20, n);
    check("to1_latency", n, Timeout);
    check("to1_tfault", bus.timeout_fault, 1'b1);
    check("to1_code", bus.fault_code, exp_code(6'b000111));
    bus.enable_request = 1'b0;
    wait_ctrl(2'b00, 40, n);
    pulse_clear();
    check("to1_exit_state", bus.state, StOff);

    // Enable dropped while waiting for rail 0.
    clear_sense();
    bus.enable_request = 1'b1;
    wait_state(StRail0Up, 5, n);
    repeat (3) step();
    bus.enable_request = 1'b0;
    step();
    check("abort_state", bus.state, StOff);
    check("abort_ctrl", bus.power_control, 2'b00);

    // Asynchronous reset while rail 1 is being enabled.
    bus.enable_request = 1'b1;
    wait_state(StRail0Up, 5, n);
    bus.power_sense = 6'b000111;
    wait_state(StRail1Up, 60, n);
    check("pre_rst_ctrl", bus.power_control, 2'b11);
    reset = 1'b1;
    #1;
    check("async_rst_ctrl", bus.power_control, 2'b00);
    check("async_rst_state", bus.state, StOff);
    bus.enable_request = 1'b0;
    step();
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
